// File: rtl/pe_network_interface.sv
// PE-side network interface: injection FIFO with ack/retry, ejection capture.
// Optional ATTO_NI_STATS_EN adds saturating sent/retry/drop counters.
`timescale 1ns/1ps
module pe_network_interface #(
    parameter int DEPTH     = 4,
    parameter int ACK_WAIT  = 3,
    parameter int MAX_RETRY = 7
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        inj_valid,
    input  logic [47:0] inj_data,
    output logic        inj_ready,
    output logic [47:0] channel_dout,
    output logic [1:0]  diff_pair_dout,
    input  logic        r2pe_ack_din,
    input  logic [39:0] channel_din,
    input  logic [1:0]  diff_pair_din,
    output logic        eject_valid,
    output logic [39:0] eject_data,
    output logic        drop_pulse
`ifdef ATTO_NI_STATS_EN
    ,
    output logic [15:0] stat_sent,
    output logic [15:0] stat_retry,
    output logic [7:0]  stat_drop
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(ACK_WAIT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state;
    logic [47:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [WW-1:0] wcnt;
    logic [7:0]    retry;
    logic          eject_ph;

    logic full;
    logic empty;
    logic push;
    logic timeout;
    logic retry_max;
    logic ack_pop;
    logic retx;
    logic drop_ev;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign inj_ready = !full;
    assign push      = inj_valid && !full;

    assign timeout   = (wcnt == WW'(ACK_WAIT - 1));
    assign retry_max = (retry == 8'(MAX_RETRY));

    // An ack in the same cycle as a timeout wins over retransmit/drop.
    assign ack_pop = (state == S_WAIT) && r2pe_ack_din;
    assign retx    = (state == S_WAIT) && !r2pe_ack_din && timeout && !retry_max;
    assign drop_ev = (state == S_WAIT) && !r2pe_ack_din && timeout && retry_max;

    always_ff @(posedge clka) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= inj_data;
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ack_pop || drop_ev) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state          <= S_IDLE;
            channel_dout   <= '0;
            diff_pair_dout <= 2'b01;
            wcnt           <= '0;
            retry          <= '0;
            drop_pulse     <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        channel_dout   <= mem[rd_ptr[AW-1:0]];
                        diff_pair_dout <= ~diff_pair_dout;
                        wcnt           <= '0;
                        retry          <= '0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ack_pop) begin
                        state <= S_IDLE;
                    end else if (retx) begin
                        diff_pair_dout <= ~diff_pair_dout;
                        retry          <= retry + 1'b1;
                        wcnt           <= '0;
                    end else if (drop_ev) begin
                        drop_pulse <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Words with equal bits are glitches and leave the stored phase alone.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            eject_ph    <= 1'b0;
            eject_valid <= 1'b0;
            eject_data  <= '0;
        end else begin
            eject_valid <= 1'b0;
            if ((diff_pair_din[1] ^ diff_pair_din[0]) &&
                (diff_pair_din[1] != eject_ph)) begin
                eject_ph    <= diff_pair_din[1];
                eject_valid <= 1'b1;
                eject_data  <= channel_din;
            end
        end
    end

`ifdef ATTO_NI_STATS_EN
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            stat_sent  <= '0;
            stat_retry <= '0;
            stat_drop  <= '0;
        end else begin
            if (ack_pop && stat_sent != '1) begin
                stat_sent <= stat_sent + 1'b1;
            end
            if (retx && stat_retry != '1) begin
                stat_retry <= stat_retry + 1'b1;
            end
            if (drop_ev && stat_drop != '1) begin
                stat_drop <= stat_drop + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_network_interface.sv
// Directed bench for pe_network_interface with a cycle-level reference model.
`timescale 1ns/1ps
module tb_pe_network_interface;
    localparam int DEPTH     = 4;
    localparam int ACK_WAIT  = 3;
    localparam int MAX_RETRY = 2;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic        inj_valid = 1'b0;
    logic [47:0] inj_data = '0;
    logic        inj_ready;
    logic [47:0] channel_dout;
    logic [1:0]  diff_pair_dout;
    logic        r2pe_ack_din = 1'b0;
    logic [39:0] channel_din = '0;
    logic [1:0]  diff_pair_din = 2'b01;
    logic        eject_valid;
    logic [39:0] eject_data;
    logic        drop_pulse;
`ifdef ATTO_NI_STATS_EN
    logic [15:0] stat_sent;
    logic [15:0] stat_retry;
    logic [7:0]  stat_drop;
`endif

    pe_network_interface #(
        .DEPTH(DEPTH), .ACK_WAIT(ACK_WAIT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clka(clka), .rsta(rsta),
        .inj_valid(inj_valid), .inj_data(inj_data), .inj_ready(inj_ready),
        .channel_dout(channel_dout), .diff_pair_dout(diff_pair_dout),
        .r2pe_ack_din(r2pe_ack_din),
        .channel_din(channel_din), .diff_pair_din(diff_pair_din),
        .eject_valid(eject_valid), .eject_data(eject_data),
        .drop_pulse(drop_pulse)
`ifdef ATTO_NI_STATS_EN
        ,
        .stat_sent(stat_sent), .stat_retry(stat_retry), .stat_drop(stat_drop)
`endif
    );

    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a packet is offered on the wire, then either acked,
    // re-offered after ACK_WAIT silent cycles, or dropped after MAX_RETRY re-offers.
    logic [47:0] mq[$];
    bit          m_busy;
    int          m_sent_at;
    int          m_tries;
    int          cyc;
    logic [47:0] m_ch;
    logic [1:0]  m_dp;
    bit          m_drop;
    bit          m_ev;
    logic [39:0] m_ed;
    bit          m_ph;

    task automatic model_reset();
        mq.delete();
        m_busy = 0;
        m_tries = 0;
        m_sent_at = 0;
        m_ch = '0;
        m_dp = 2'b01;
        m_drop = 0;
        m_ev = 0;
        m_ed = '0;
        m_ph = 0;
    endtask

    initial begin
        bit push;
        cyc = 0;
        model_reset();
        forever begin
            @(negedge clka);
            cyc++;
            if (!rsta) model_reset();
            check("inj_ready", 64'(inj_ready), 64'(mq.size() < DEPTH));
            check("channel_dout", 64'(channel_dout), 64'(m_ch));
            check("diff_pair_dout", 64'(diff_pair_dout), 64'(m_dp));
            check("drop_pulse", 64'(drop_pulse), 64'(m_drop));
            check("eject_valid", 64'(eject_valid), 64'(m_ev));
            check("eject_data", 64'(eject_data), 64'(m_ed));
            if (rsta) begin
                push = inj_valid && (mq.size() < DEPTH);
                m_drop = 0;
                if (m_busy) begin
                    if (r2pe_ack_din) begin
                        void'(mq.pop_front());
                        m_busy = 0;
                    end else if (cyc == m_sent_at + ACK_WAIT - 1) begin
                        if (m_tries < MAX_RETRY) begin
                            m_tries++;
                            m_dp = ~m_dp;
                            m_sent_at = cyc + 1;
                        end else begin
                            void'(mq.pop_front());
                            m_busy = 0;
                            m_drop = 1;
                        end
                    end
                end else if (mq.size() > 0) begin
                    m_ch = mq[0];
                    m_dp = ~m_dp;
                    m_busy = 1;
                    m_tries = 0;
                    m_sent_at = cyc + 1;
                end
                if (push) mq.push_back(inj_data);
                m_ev = 0;
                if ((diff_pair_din[1] != diff_pair_din[0]) &&
                    (diff_pair_din[1] != m_ph)) begin
                    m_ph = diff_pair_din[1];
                    m_ev = 1;
                    m_ed = channel_din;
                end
            end
        end
    end

    int tog = 0;
    int drop_cnt = 0;
    int ev_cnt = 0;
    logic [1:0] dp_prev = 2'b01;

    initial begin
        forever begin
            @(negedge clka);
            if (rsta && diff_pair_dout != dp_prev) tog++;
            if (rsta && drop_pulse) drop_cnt++;
            if (rsta && eject_valid) ev_cnt++;
            dp_prev = diff_pair_dout;
        end
    end

    int consumed = 0;

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic push(input logic [47:0] d);
        inj_valid = 1'b1;
        inj_data = d;
        step();
        inj_valid = 1'b0;
    endtask

    // Returns one cycle after a toggle; n is the distance from the previous reference.
    task automatic wait_tog(output int n);
        n = 0;
        while (tog <= consumed && n < 40) begin
            step();
            n++;
        end
        if (tog <= consumed) begin
            checks++;
            errors++;
            $display("FAIL toggle_timeout actual=none required=toggle");
        end else begin
            consumed++;
        end
    endtask

    task automatic ack_t2();
        step();
        r2pe_ack_din = 1'b1;
        step();
        r2pe_ack_din = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [47:0] burst [5];
        burst[0] = 48'h0000_0000_F000;
        burst[1] = 48'h0000_0000_F001;
        burst[2] = 48'h0000_0000_F002;
        burst[3] = 48'h0000_0000_F003;
        burst[4] = 48'h0000_0000_F004;

        repeat (3) step();
        check("rst_dp", 64'(diff_pair_dout), 64'h1);
        check("rst_ready", 64'(inj_ready), 64'h1);
        check("rst_ch", 64'(channel_dout), 64'h0);
        rsta = 1'b1;
        repeat (2) step();

        push(48'hA5A5_0000_1234);
        wait_tog(n);
        check("single_latency", 64'(n), 64'd2);
        check("single_dp", 64'(diff_pair_dout), 64'h2);
        check("single_ch", 64'(channel_dout), 64'hA5A5_0000_1234);
        ack_t2();
        repeat (6) step();
        check("single_no_retx", 64'(tog), 64'(consumed));

        push(48'h0000_BEEF_0002);
        wait_tog(n);
        check("retry_first", 64'(n), 64'd2);
        wait_tog(n);
        check("retry_gap", 64'(n), 64'd3);
        check("retry_dp", 64'(diff_pair_dout), 64'h2);
        ack_t2();
        repeat (6) step();
        check("retry_no_more", 64'(tog), 64'(consumed));

        push(48'h0000_0000_0D03);
        push(48'h0000_0000_0D04);
        wait_tog(n);
        check("drop_first", 64'(n), 64'd1);
        wait_tog(n);
        check("drop_retx1", 64'(n), 64'd3);
        wait_tog(n);
        check("drop_retx2", 64'(n), 64'd3);
        wait_tog(n);
        check("drop_next_gap", 64'(n), 64'd4);
        check("drop_next_ch", 64'(channel_dout), 64'h0000_0000_0D04);
        check("drop_count", 64'(drop_cnt), 64'd1);
        ack_t2();
        repeat (6) step();

        inj_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inj_data = burst[i];
            check("full_ready_pre", 64'(inj_ready), 64'h1);
            step();
        end
        check("full_ready_0", 64'(inj_ready), 64'h0);
        inj_data = burst[4];
        r2pe_ack_din = 1'b1;
        step();
        r2pe_ack_din = 1'b0;
        check("full_ready_after_pop", 64'(inj_ready), 64'h1);
        step();
        check("full_ready_refill", 64'(inj_ready), 64'h0);
        inj_valid = 1'b0;
        consumed = tog;
        for (int i = 1; i < 5; i++) begin
            wait_tog(n);
            check("drain_ch", 64'(channel_dout), 64'(burst[i]));
            ack_t2();
        end
        repeat (6) step();
        check("drain_idle", 64'(tog), 64'(consumed));

        diff_pair_din = 2'b11;
        channel_din = 40'h99;
        step();
        diff_pair_din = 2'b10;
        channel_din = 40'h11;
        step();
        channel_din = 40'h33;
        step();
        diff_pair_din = 2'b01;
        channel_din = 40'h22;
        repeat (3) step();
        check("eject_count", 64'(ev_cnt), 64'd2);
        check("eject_last", 64'(eject_data), 64'h22);

`ifdef ATTO_NI_STATS_EN
        check("stat_sent", 64'(stat_sent), 64'd8);
        check("stat_retry", 64'(stat_retry), 64'd3);
        check("stat_drop", 64'(stat_drop), 64'd1);
`endif

        push(48'h0000_0000_0E05);
        wait_tog(n);
        check("rstmid_latency", 64'(n), 64'd2);
        step();
        rsta = 1'b0;
        step();
        check("rstmid_dp", 64'(diff_pair_dout), 64'h1);
        check("rstmid_ch", 64'(channel_dout), 64'h0);
        check("rstmid_ready", 64'(inj_ready), 64'h1);
        check("rstmid_drop", 64'(drop_pulse), 64'h0);
        check("rstmid_ev", 64'(eject_valid), 64'h0);
        check("rstmid_ed", 64'(eject_data), 64'h0);
        step();
        rsta = 1'b1;
        repeat (10) step();
        check("rstmid_no_drop", 64'(drop_cnt), 64'd1);
        check("rstmid_no_send", 64'(tog), 64'(consumed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
